novck_monitor: RTL and testbench

- On-chip checker downstream of the non-overlapping two-phase clock generator.
- Samples CK1/CK1_b/CK2/CK2_b on a fast free-running sample clock and tracks the phase sequence with an FSM.
- Flags overlap, complement, ordering, dead-time and stall faults; reports minimum dead time, period count and a lock indication to status logic.

---
 rtl/novck_mon_pkg.sv | 34 +++
 rtl/novck_sync.sv | 36 +++
 rtl/novck_monitor.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_novck_monitor.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/novck_mon_pkg.sv
// Shared types and defaults for the two-phase non-overlapping clock monitor.
package novck_mon_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PH1   = 3'd1,
      ST_GAP12 = 3'd2,
      ST_PH2   = 3'd3,
      ST_GAP21 = 3'd4
   } mon_state_e;

   localparam int SYNC_STAGES_DEF  = 2;
   localparam int GAP_W_DEF        = 8;
   localparam int CNT_W_DEF        = 16;
   localparam int MIN_GAP_DEF      = 1;
   localparam int COMPL_TOL_DEF    = 1;
   localparam int TIMEOUT_DEF      = 255;
   localparam int LOCK_PERIODS_DEF = 4;

   localparam int ERR_OVERLAP = 0;
   localparam int ERR_COMPL   = 1;
   localparam int ERR_SEQ     = 2;
   localparam int ERR_GAP     = 3;
   localparam int ERR_STALL   = 4;
   localparam int ERR_W       = 5;

   // Synchronizer bit order is {CK2_b, CK2, CK1_b, CK1}; idle level is both phases low.
   localparam logic [3:0] SYNC_RST_VAL = 4'b1010;

   function automatic logic is_gap(input mon_state_e s);
      return (s == ST_GAP12) || (s == ST_GAP21);
   endfunction

endpackage

// File: rtl/novck_sync.sv
// Multi-stage synchronizer for a small vector of asynchronous inputs,
// with a per-bit reset value.
module novck_sync #(
   parameter int           STAGES  = 2,
   parameter int           W       = 4,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk_sys,
   input  logic         rst_b,
   input  logic [W-1:0] d_in,
   output logic [W-1:0] d_out
);

   logic [W-1:0] stage_q [STAGES];
   logic [W-1:0] stage_d [STAGES];

   always_comb begin
      stage_d[0] = d_in;
      for (int i = 1; i < STAGES; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= RST_VAL;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign d_out = stage_q[STAGES-1];

endmodule

// File: rtl/novck_monitor.sv
// Checker for a non-overlapping two-phase clock: overlap, complement, order,
// dead-time and stall faults, plus min dead time, period count and lock.
// Optional NOVCK_MON_DUTY_EN adds ck1_high/ck2_high high-time outputs.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | waiting for a clean CK1 rise (after reset, overlap or !en)
// ST_PH1   | CK1 high
// ST_GAP12 | dead time after CK1 fall, waiting for CK2 rise
// ST_PH2   | CK2 high
// ST_GAP21 | dead time after CK2 fall, waiting for CK1 rise
module novck_monitor
   import novck_mon_pkg::*;
#(
   parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
   parameter int GAP_W        = GAP_W_DEF,
   parameter int CNT_W        = CNT_W_DEF,
   parameter int MIN_GAP      = MIN_GAP_DEF,
   parameter int COMPL_TOL    = COMPL_TOL_DEF,
   parameter int TIMEOUT      = TIMEOUT_DEF,
   parameter int LOCK_PERIODS = LOCK_PERIODS_DEF
) (
   input  logic             CK,
   input  logic             RST_b,
   input  logic             CK1,
   input  logic             CK1_b,
   input  logic             CK2,
   input  logic             CK2_b,
   input  logic             en,
   input  logic             clr,
   output logic             overlap_err,
   output logic             compl_err,
   output logic             seq_err,
   output logic             gap_err,
   output logic             stall_err,
   output logic [GAP_W-1:0] min_gap,
   output logic [CNT_W-1:0] phase_cnt,
   output logic             locked
`ifdef NOVCK_MON_DUTY_EN
   ,
   output logic [GAP_W-1:0] ck1_high,
   output logic [GAP_W-1:0] ck2_high
`endif
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam int CC_W = $clog2(COMPL_TOL + 2);
   localparam int LK_W = $clog2(LOCK_PERIODS + 1);

   localparam logic [GAP_W-1:0] MIN_GAP_V = GAP_W'(MIN_GAP);
   localparam logic [WD_W-1:0]  TIMEOUT_V = WD_W'(TIMEOUT);
   localparam logic [CC_W-1:0]  CC_MAX    = CC_W'(COMPL_TOL + 1);
   localparam logic [LK_W-1:0]  LOCK_V    = LK_W'(LOCK_PERIODS);

   logic [3:0]       sync_in;
   logic [3:0]       sync_out;
   logic             c1, c1b, c2, c2b;

   mon_state_e       state_q, state_d;
   logic             fsm_overlap, fsm_seq;
   logic             gap_exit, period_done, state_chg;
   logic [GAP_W-1:0] gap_val, gap_inc;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [GAP_W-1:0] mg_base, min_gap_q, min_gap_d;
   logic [ERR_W-1:0] err_q, err_d, err_set;
   logic [WD_W-1:0]  wdog_q, wdog_d;
   logic [1:0]       pair_mm;
   logic [CC_W-1:0]  cc_q [2];
   logic [CC_W-1:0]  cc_d [2];
   logic             compl_hit;
   logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
   logic [LK_W-1:0]  streak_q, streak_d;
   logic             locked_q, locked_d;

   assign sync_in = {CK2_b, CK2, CK1_b, CK1};

   novck_sync #(
      .STAGES  (SYNC_STAGES),
      .W       (4),
      .RST_VAL (SYNC_RST_VAL)
   ) u_sync (
      .clk_sys (CK),
      .rst_b   (RST_b),
      .d_in    (sync_in),
      .d_out   (sync_out)
   );

   assign c1  = sync_out[0];
   assign c1b = sync_out[1];
   assign c2  = sync_out[2];
   assign c2b = sync_out[3];

   // Dead time including the current sample; used when a gap state is left.
   assign gap_inc = (gap_cnt_q == '1) ? gap_cnt_q : gap_cnt_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      fsm_overlap = 1'b0;
      fsm_seq     = 1'b0;
      gap_exit    = 1'b0;
      gap_val     = '0;
      period_done = 1'b0;
      if (!en) begin
         state_d = ST_IDLE;
      end else if (c1 && c2) begin
         fsm_overlap = 1'b1;
         state_d     = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (c1) state_d = ST_PH1;
            end
            ST_PH1: begin
               if (!c1) begin
                  if (c2) begin
                     state_d  = ST_PH2;
                     gap_exit = 1'b1;
                  end else begin
                     state_d = ST_GAP12;
                  end
               end
            end
            ST_GAP12: begin
               if (c1) begin
                  fsm_seq = 1'b1;
                  state_d = ST_PH1;
               end else if (c2) begin
                  state_d  = ST_PH2;
                  gap_exit = 1'b1;
                  gap_val  = gap_inc;
               end
            end
            ST_PH2: begin
               if (!c2) begin
                  if (c1) begin
                     state_d     = ST_PH1;
                     gap_exit    = 1'b1;
                     period_done = 1'b1;
                  end else begin
                     state_d = ST_GAP21;
                  end
               end
            end
            ST_GAP21: begin
               if (c2) begin
                  fsm_seq = 1'b1;
                  state_d = ST_PH2;
               end else if (c1) begin
                  state_d     = ST_PH1;
                  gap_exit    = 1'b1;
                  gap_val     = gap_inc;
                  period_done = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      state_chg = (state_d != state_q);

      gap_cnt_d = gap_cnt_q;
      if (en) begin
         if (is_gap(state_d) && state_chg) gap_cnt_d = '0;
         else if (is_gap(state_q))         gap_cnt_d = gap_inc;
      end

      if (!en || state_chg)         wdog_d = '0;
      else if (wdog_q != TIMEOUT_V) wdog_d = wdog_q + 1'b1;
      else                          wdog_d = wdog_q;

      pair_mm = {c2 == c2b, c1 == c1b};
      for (int p = 0; p < 2; p++) begin
         cc_d[p] = cc_q[p];
         if (en) begin
            if (state_q == ST_IDLE || !pair_mm[p]) cc_d[p] = '0;
            else if (cc_q[p] != CC_MAX)            cc_d[p] = cc_q[p] + 1'b1;
         end
      end
      compl_hit = ((cc_d[0] == CC_MAX) && (cc_q[0] != CC_MAX)) ||
                  ((cc_d[1] == CC_MAX) && (cc_q[1] != CC_MAX));

      err_set              = '0;
      err_set[ERR_OVERLAP] = fsm_overlap;
      err_set[ERR_SEQ]     = fsm_seq;
      err_set[ERR_GAP]     = gap_exit && (gap_val < MIN_GAP_V);
      err_set[ERR_COMPL]   = compl_hit;
      err_set[ERR_STALL]   = (wdog_d == TIMEOUT_V) && (wdog_q != TIMEOUT_V);

      // A new error event wins over a simultaneous clr.
      err_d       = (clr ? '0 : err_q) | err_set;
      mg_base     = clr ? '1 : min_gap_q;
      min_gap_d   = (gap_exit && (gap_val < mg_base)) ? gap_val : mg_base;
      phase_cnt_d = (clr ? '0 : phase_cnt_q) + CNT_W'(period_done);

      if (!en || clr || (|err_set))                 streak_d = '0;
      else if (period_done && (streak_q != LOCK_V)) streak_d = streak_q + 1'b1;
      else                                          streak_d = streak_q;
      locked_d = (streak_d == LOCK_V);
   end

   always_ff @(posedge CK or negedge RST_b) begin
      if (!RST_b) begin
         state_q     <= ST_IDLE;
         gap_cnt_q   <= '0;
         wdog_q      <= '0;
         cc_q[0]     <= '0;
         cc_q[1]     <= '0;
         err_q       <= '0;
         min_gap_q   <= '1;
         phase_cnt_q <= '0;
         streak_q    <= '0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         gap_cnt_q   <= gap_cnt_d;
         wdog_q      <= wdog_d;
         cc_q        <= cc_d;
         err_q       <= err_d;
         min_gap_q   <= min_gap_d;
         phase_cnt_q <= phase_cnt_d;
         streak_q    <= streak_d;
         locked_q    <= locked_d;
      end
   end

   assign overlap_err = err_q[ERR_OVERLAP];
   assign compl_err   = err_q[ERR_COMPL];
   assign seq_err     = err_q[ERR_SEQ];
   assign gap_err     = err_q[ERR_GAP];
   assign stall_err   = err_q[ERR_STALL];
   assign min_gap     = min_gap_q;
   assign phase_cnt   = phase_cnt_q;
   assign locked      = locked_q;

`ifdef NOVCK_MON_DUTY_EN
   logic [GAP_W-1:0] hi1_cnt_q, hi1_cnt_d, hi2_cnt_q, hi2_cnt_d;
   logic [GAP_W-1:0] ck1_high_q, ck1_high_d, ck2_high_q, ck2_high_d;

   // High time counts the entry sample; only a legal phase exit publishes it.
   always_comb begin
      hi1_cnt_d  = hi1_cnt_q;
      hi2_cnt_d  = hi2_cnt_q;
      ck1_high_d = clr ? '0 : ck1_high_q;
      ck2_high_d = clr ? '0 : ck2_high_q;
      if (en) begin
         if (state_d == ST_PH1 && state_q != ST_PH1) begin
            hi1_cnt_d = GAP_W'(1);
         end else if (state_q == ST_PH1) begin
            if (state_d == ST_PH1) begin
               if (hi1_cnt_q != '1) hi1_cnt_d = hi1_cnt_q + 1'b1;
            end else if (state_d != ST_IDLE) begin
               ck1_high_d = hi1_cnt_q;
            end
         end
         if (state_d == ST_PH2 && state_q != ST_PH2) begin
            hi2_cnt_d = GAP_W'(1);
         end else if (state_q == ST_PH2) begin
            if (state_d == ST_PH2) begin
               if (hi2_cnt_q != '1) hi2_cnt_d = hi2_cnt_q + 1'b1;
            end else if (state_d != ST_IDLE) begin
               ck2_high_d = hi2_cnt_q;
            end
         end
      end
   end

   always_ff @(posedge CK or negedge RST_b) begin
      if (!RST_b) begin
         hi1_cnt_q  <= '0;
         hi2_cnt_q  <= '0;
         ck1_high_q <= '0;
         ck2_high_q <= '0;
      end else begin
         hi1_cnt_q  <= hi1_cnt_d;
         hi2_cnt_q  <= hi2_cnt_d;
         ck1_high_q <= ck1_high_d;
         ck2_high_q <= ck2_high_d;
      end
   end

   assign ck1_high = ck1_high_q;
   assign ck2_high = ck2_high_q;
`endif

endmodule

// File: tb/tb_novck_monitor.sv
// Directed bench for novck_monitor: clean periods, overlap, zero gap,
// complement mismatch, stall and mid-period reset.
module tb_novck_monitor;

   logic        CK = 1'b0;
   logic        RST_b;
   logic        ck1, ck1_b, ck2, ck2_b;
   logic        en, clr;
   logic        overlap_err, compl_err, seq_err, gap_err, stall_err;
   logic [7:0]  min_gap;
   logic [15:0] phase_cnt;
   logic        locked;
`ifdef NOVCK_MON_DUTY_EN
   logic [7:0]  ck1_high, ck2_high;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   novck_monitor dut (
      .CK          (CK),
      .RST_b       (RST_b),
      .CK1         (ck1),
      .CK1_b       (ck1_b),
      .CK2         (ck2),
      .CK2_b       (ck2_b),
      .en          (en),
      .clr         (clr),
      .overlap_err (overlap_err),
      .compl_err   (compl_err),
      .seq_err     (seq_err),
      .gap_err     (gap_err),
      .stall_err   (stall_err),
      .min_gap     (min_gap),
      .phase_cnt   (phase_cnt),
      .locked      (locked)
`ifdef NOVCK_MON_DUTY_EN
      ,
      .ck1_high    (ck1_high),
      .ck2_high    (ck2_high)
`endif
   );

   always #5 CK = ~CK;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One sample: drive all four pins, then step past the next CK edge.
   task automatic step4(input logic a, input logic ab, input logic b, input logic bb);
      ck1 = a; ck1_b = ab; ck2 = b; ck2_b = bb;
      @(posedge CK);
      #1;
   endtask

   task automatic hold(input logic a, input logic b, input int n);
      for (int i = 0; i < n; i++) step4(a, ~a, b, ~b);
   endtask

   task automatic period();
      hold(1'b1, 1'b0, 8);
      hold(1'b0, 1'b0, 3);
      hold(1'b0, 1'b1, 8);
      hold(1'b0, 1'b0, 3);
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      hold(1'b0, 1'b0, 1);
      clr = 1'b0;
   endtask

   function automatic logic [4:0] errs();
      return {overlap_err, compl_err, seq_err, gap_err, stall_err};
   endfunction

   initial begin
      RST_b = 1'b0; en = 1'b1; clr = 1'b0;
      ck1 = 1'b0; ck1_b = 1'b1; ck2 = 1'b0; ck2_b = 1'b1;
      repeat (3) @(posedge CK);
      #1;
      check_eq("rst_errs", 32'(errs()), 32'd0);
      check_eq("rst_min_gap", 32'(min_gap), 32'd255);
      check_eq("rst_phase_cnt", 32'(phase_cnt), 32'd0);
      check_eq("rst_locked", 32'(locked), 32'd0);
      RST_b = 1'b1;
      hold(1'b0, 1'b0, 2);

      // Clean stream; the first CK1 rise leaves IDLE and is not a completed period.
      repeat (4) period();
      check_eq("clean_cnt3", 32'(phase_cnt), 32'd3);
      check_eq("clean_unlocked3", 32'(locked), 32'd0);
      period();
      check_eq("clean_cnt4", 32'(phase_cnt), 32'd4);
      check_eq("clean_locked4", 32'(locked), 32'd1);
      repeat (6) period();
      check_eq("clean_cnt10", 32'(phase_cnt), 32'd10);
      check_eq("clean_errs", 32'(errs()), 32'd0);
      check_eq("clean_min_gap", 32'(min_gap), 32'd3);
      check_eq("clean_locked", 32'(locked), 32'd1);

      // Overlap: CK2 rises two samples before CK1 falls.
      hold(1'b1, 1'b0, 6);
      hold(1'b1, 1'b1, 2);
      check_eq("ovl_not_yet", 32'(overlap_err), 32'd0);
      hold(1'b0, 1'b1, 1);
      check_eq("ovl_set", 32'(overlap_err), 32'd1);
      check_eq("ovl_unlocked", 32'(locked), 32'd0);
      hold(1'b0, 1'b1, 5);
      hold(1'b0, 1'b0, 3);
      pulse_clr();
      check_eq("clr_ovl", 32'(overlap_err), 32'd0);
      check_eq("clr_phase_cnt", 32'(phase_cnt), 32'd0);
      check_eq("clr_min_gap", 32'(min_gap), 32'd255);
      repeat (4) period();
      check_eq("relock_cnt3", 32'(phase_cnt), 32'd3);
      check_eq("relock_unlocked", 32'(locked), 32'd0);
      period();
      check_eq("relock_locked", 32'(locked), 32'd1);
      check_eq("relock_min_gap", 32'(min_gap), 32'd3);

      // Zero dead time: same-sample handoff from CK1 to CK2.
      hold(1'b1, 1'b0, 8);
      hold(1'b0, 1'b1, 8);
      hold(1'b0, 1'b0, 3);
      check_eq("gap0_min_gap", 32'(min_gap), 32'd0);
      check_eq("gap0_gap_err", 32'(gap_err), 32'd1);
      check_eq("gap0_no_ovl", 32'(overlap_err), 32'd0);
      check_eq("gap0_no_seq", 32'(seq_err), 32'd0);
      check_eq("gap0_unlocked", 32'(locked), 32'd0);
      pulse_clr();
      check_eq("clr_gap_err", 32'(gap_err), 32'd0);

      // Complement: one mismatching sample is tolerated, three are not.
      hold(1'b1, 1'b0, 4);
      step4(1'b1, 1'b1, 1'b0, 1'b1);
      hold(1'b1, 1'b0, 3);
      hold(1'b0, 1'b0, 3);
      hold(1'b0, 1'b1, 8);
      hold(1'b0, 1'b0, 3);
      check_eq("compl_1samp", 32'(compl_err), 32'd0);
      hold(1'b1, 1'b0, 3);
      for (int i = 0; i < 3; i++) step4(1'b1, 1'b1, 1'b0, 1'b1);
      hold(1'b1, 1'b0, 2);
      hold(1'b0, 1'b0, 3);
      hold(1'b0, 1'b1, 8);
      hold(1'b0, 1'b0, 3);
      check_eq("compl_3samp", 32'(compl_err), 32'd1);
      check_eq("compl_no_seq", 32'(seq_err), 32'd0);

      // Stall: CK1 frozen high; PH1 entered 2 edges after the rise, stall 255 later.
      pulse_clr();
      check_eq("stall_clr_compl", 32'(compl_err), 32'd0);
      hold(1'b1, 1'b0, 257);
      check_eq("stall_before", 32'(stall_err), 32'd0);
      hold(1'b1, 1'b0, 1);
      check_eq("stall_at_timeout", 32'(stall_err), 32'd1);
      hold(1'b1, 1'b0, 42);
      check_eq("stall_phase_cnt", 32'(phase_cnt), 32'd1);
      check_eq("stall_unlocked", 32'(locked), 32'd0);

      // Reset in the middle of PH2, then clean periods from IDLE.
      hold(1'b0, 1'b0, 3);
      hold(1'b0, 1'b1, 4);
      RST_b = 1'b0;
      #2;
      check_eq("midrst_errs", 32'(errs()), 32'd0);
      check_eq("midrst_min_gap", 32'(min_gap), 32'd255);
      check_eq("midrst_phase_cnt", 32'(phase_cnt), 32'd0);
      check_eq("midrst_locked", 32'(locked), 32'd0);
      repeat (2) @(posedge CK);
      #1;
      RST_b = 1'b1;
      hold(1'b0, 1'b1, 4);
      hold(1'b0, 1'b0, 3);
      repeat (3) period();
      check_eq("post_rst_errs", 32'(errs()), 32'd0);
      check_eq("post_rst_cnt", 32'(phase_cnt), 32'd2);
      check_eq("post_rst_min_gap", 32'(min_gap), 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
